// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtraction controller.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_t;

  // Bit-index counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake plus operand and result bundle.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow_out, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow_out, ovf, zero
  );
endinterface

// File: rtl/fs_using_hs.sv
// Full-subtractor cell built from two half-subtractors: diff = a - b - c.
module fs_using_hs (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);
  logic d1, b1, b2;

  assign d1     = a ^ b;
  assign b1     = ~a & b;
  assign diff   = d1 ^ c;
  assign b2     = ~d1 & c;
  assign borrow = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin controller: one shared full-subtractor, LSB first,
// WIDTH cycles per operation with registered result and flags.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_sub_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, d_sh_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q, a_msb_q, b_msb_q;
  logic             busy_q, done_q, bo_q, ovf_q, zero_q;

  logic             d, bo;
  logic [WIDTH-1:0] d_sh_d;

  fs_using_hs u_cell (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .c      (brw_q),
    .diff   (d),
    .borrow (bo)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place.
  always_comb begin
    d_sh_d = (d_sh_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          d_sh_q <= d_sh_d;
          brw_q  <= bo;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            diff_q  <= d_sh_d;
            bo_q    <= bo;
            zero_q  <= (d_sh_d == '0);
            // d is the result MSB on this final cycle.
            ovf_q   <= (a_msb_q != b_msb_q) && (d != a_msb_q);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
  assign bus.ovf        = ovf_q;
  assign bus.zero       = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH = 8 and WIDTH = 1 instances).
module tb_serial_sub_ctrl;

  typedef struct packed {
    logic [7:0] diff;
    logic       bo;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl_if #(.WIDTH(8)) s8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) s1 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(s8));
  serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(s1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    res_t       e;
    r      = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.diff = r[7:0];
    e.bo   = r[8];
    e.ovf  = (a[7] != b[7]) && (r[7] != a[7]);
    e.zero = (r[7:0] == 8'd0);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    res_t e;
    #1;
    if (s8.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("diff", {24'd0, s8.diff}, {24'd0, e.diff});
        chk("borrow_out", {31'd0, s8.borrow_out}, {31'd0, e.bo});
        chk("ovf", {31'd0, s8.ovf}, {31'd0, e.ovf});
        chk("zero", {31'd0, s8.zero}, {31'd0, e.zero});
      end
    end
  end

  task automatic wait_busy(output bit ok);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!s8.busy && n < 30);
    ok = s8.busy;
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!s8.done && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (!s8.done) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input res_t exp);
    bit ok;
    int n;
    @(negedge clk);
    s8.a = a; s8.b = b; s8.bin = bin; s8.start = 1'b1;
    wait_busy(ok);
    s8.start = 1'b0;
    if (ok) begin
      exp_q.push_back(exp);
      wait_done(n);
      chk("latency", n, 8);
    end
  endtask

  vec_t vecs[6];

  initial begin
    bit   ok;
    int   n, hits;
    int   acc[3];
    logic [7:0] ra, rb;
    logic rbin;

    vecs[0] = '{8'd5,   8'd3,   1'b0, {8'h02, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{8'd3,   8'd5,   1'b0, {8'hFE, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{8'h80,  8'h01,  1'b0, {8'h7F, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{8'h00,  8'h00,  1'b1, {8'hFF, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{8'h7F,  8'hFF,  1'b0, {8'h80, 1'b1, 1'b1, 1'b0}};
    vecs[5] = '{8'hFF,  8'hFF,  1'b1, {8'hFF, 1'b1, 1'b0, 1'b0}};

    rst_n = 1'b0;
    s8.start = 1'b0; s8.a = '0; s8.b = '0; s8.bin = 1'b0;
    s1.start = 1'b0; s1.a = '0; s1.b = '0; s1.bin = 1'b0;
    #12;
    chk("reset8", {20'd0, s8.busy, s8.done, s8.diff, s8.borrow_out, s8.ovf, s8.zero}, 32'd0);
    chk("reset1", {26'd0, s1.busy, s1.done, s1.diff, s1.borrow_out, s1.ovf, s1.zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);

    // Equal operands, plus a start request mid-operation that must be dropped.
    @(negedge clk);
    s8.a = 8'h5A; s8.b = 8'h5A; s8.bin = 1'b0; s8.start = 1'b1;
    wait_busy(ok);
    s8.start = 1'b0;
    exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    s8.a = 8'h11; s8.b = 8'h22; s8.bin = 1'b1; s8.start = 1'b1;
    @(posedge clk); #1;
    chk("hold_diff_during_shift", {24'd0, s8.diff}, 32'hFF);
    chk("busy_mid_op", {31'd0, s8.busy}, 32'd1);
    wait_done(n);
    chk("latency_ignored_start", n, 5);
    s8.start = 1'b0;
    hits = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (s8.busy) hits++;
    end
    chk("ignored_no_restart", hits, 0);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      do_op(ra, rb, rbin, model(ra, rb, rbin));
    end

    // Reset mid-operation after a nonzero result.
    do_op(8'h40, 8'h01, 1'b0, {8'h3F, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    s8.a = 8'h33; s8.b = 8'h11; s8.start = 1'b1;
    wait_busy(ok);
    s8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear",
        {20'd0, s8.busy, s8.done, s8.diff, s8.borrow_out, s8.ovf, s8.zero}, 32'd0);
    hits = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (s8.done) hits++;
    end
    chk("no_done_in_reset", hits, 0);
    @(negedge clk); rst_n = 1'b1;
    do_op(8'd9, 8'd4, 1'b0, {8'h05, 1'b0, 1'b0, 1'b0});

    // Start held high: accepting edges spaced WIDTH + 2 apart.
    @(negedge clk);
    s8.a = 8'h10; s8.b = 8'h01; s8.bin = 1'b0; s8.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_busy(ok);
      acc[k] = cyc;
      if (ok) exp_q.push_back({8'h0F, 1'b0, 1'b0, 1'b0});
      wait_done(n);
    end
    s8.start = 1'b0;
    chk("b2b_spacing_0", acc[1] - acc[0], 10);
    chk("b2b_spacing_1", acc[2] - acc[1], 10);

    // WIDTH = 1 instance: 1 - 1 - 1 and 1 - 0 - 0.
    @(negedge clk);
    s1.a = 1'b1; s1.b = 1'b1; s1.bin = 1'b1; s1.start = 1'b1;
    @(posedge clk); #1;
    chk("w1_accept_busy", {31'd0, s1.busy}, 32'd1);
    s1.start = 1'b0;
    @(posedge clk); #1;
    chk("w1_done_e1", {31'd0, s1.done}, 32'd1);
    chk("w1_result", {28'd0, s1.diff, s1.borrow_out, s1.ovf, s1.zero}, {28'd0, 4'b1100});
    @(posedge clk); #1;
    chk("w1_done_pulse", {31'd0, s1.done}, 32'd0);
    @(negedge clk);
    s1.a = 1'b1; s1.b = 1'b0; s1.bin = 1'b0; s1.start = 1'b1;
    @(posedge clk); #1;
    s1.start = 1'b0;
    @(posedge clk); #1;
    chk("w1_done_2", {31'd0, s1.done}, 32'd1);
    chk("w1_result_2", {28'd0, s1.diff, s1.borrow_out, s1.ovf, s1.zero}, {28'd0, 4'b1000});

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. One full-subtractor cell is time-shared across all bit positions, LSB first, so a WIDTH-bit difference A − B − Bin takes WIDTH cycles. The controller uses a start/busy/done handshake: it captures the operands, drives the cell one bit per cycle, carries the borrow in a flop, and presents registered result and flags.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 1.
- CNT_W, derived as $clog2(WIDTH) with a minimum of 1, bit-index counter width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered difference.
- borrow_out  output  1  final borrow, meaning unsigned a < b + bin.
- ovf  output  1  signed overflow of a − b − bin.
- zero  output  1  high when diff == 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state = IDLE; busy, done, borrow_out, ovf, zero = 0; diff = 0; all internal shift registers, the borrow flop and the counter = 0.
- States: IDLE, SHIFT, DONE (one-hot or binary, implementer's choice).
- IDLE:
  - If start = 1 at edge E0: load a_sh = a, b_sh = b, brw = bin, cnt = 0, latch a[WIDTH−1] and b[WIDTH−1] for ovf; go to SHIFT.
  - If start = 0: stay in IDLE.
- SHIFT, each cycle:
  - Cell inputs are (a_sh[0], b_sh[0], brw). Cell outputs are d and bo.
  - d shifts into d_sh at the MSB, with d_sh shifting right.
  - a_sh and b_sh shift right; brw ← bo; cnt ← cnt + 1.
  - busy = 1 for the whole state.
- SHIFT → DONE: on the edge where cnt == WIDTH−1, i.e. edge E_WIDTH. On that edge:
  - diff ← final d_sh, including the last bit.
  - borrow_out ← bo.
  - zero ← (final diff == 0).
  - ovf ← (a_msb ≠ b_msb) and (diff_msb ≠ a_msb).
- DONE: done = 1 for exactly one cycle, busy = 0. Next state is unconditionally IDLE; start is ignored in DONE.
- Latency: result and done appear WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles when start is held high.
- Output holding: diff, borrow_out, ovf and zero hold their values until the next operation completes. They never show partial results during SHIFT.
- start while busy or in DONE: ignored, with no queuing. a, b and bin may change freely after E0 with no effect.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no done pulse.
- WIDTH = 1: SHIFT lasts one cycle (cnt == 0 == WIDTH−1), so DONE follows at E1.
- Arithmetic: modulo 2^WIDTH. borrow_out equals the MSB of the (WIDTH+1)-bit result of {0,a} − {0,b} − bin.

Decomposition:
- Shared constants package/include: state encodings (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module: one instance of the existing fs_using_hs full-subtractor cell as the shared datapath. Port mapping: a = a_sh[0], b = b_sh[0], c = brw, diff = d, borrow = bo.
- All control (FSM, counter, shift registers, flag logic) is in serial_sub_ctrl.

Test Plan:
- a = 8'd5, b = 8'd3, bin = 0, start at E0 → busy during E1..E7, done at E8, diff = 8'h02, borrow_out = 0, ovf = 0, zero = 0.
- a = 8'd3, b = 8'd5, bin = 0 → diff = 8'hFE, borrow_out = 1, ovf = 0, zero = 0.
- a = 8'h80, b = 8'h01, bin = 0 → diff = 8'h7F, borrow_out = 0, ovf = 1. Then a = 8'h00, b = 8'h00, bin = 1 → diff = 8'hFF, borrow_out = 1, ovf = 0.
- a = b = 8'h5A, bin = 0 → diff = 0, zero = 1. Start a second op at E3 with different operands → ignored, and the result is unchanged.
- Start an op, deassert rst_n at E4 → busy, done and outputs = 0 asynchronously, no done pulse. After release, a fresh 8'd9 − 8'd4 → diff = 8'h05 exactly 8 edges after acceptance.
- Hold start high for back-to-back ops → accepting edges are spaced WIDTH+2 apart. Repeat with WIDTH = 1: 1 − 1 − 1 → diff = 1, borrow_out = 1, done at E1.
